// File: rtl/icache_assoc_if.sv
// icache_assoc_if -- fetch-side and memory-side signal bundle of the
// set-associative instruction cache.
//   Datapath side : imemREN, imemaddr, iflush (to cache); ihit, imemload (from cache)
//   Memory side   : iREN, iaddr (from cache); iwait, iload (to cache)
//   Statistics    : hit_count, miss_count (from cache)
// Modports: slave = the cache itself, master = the surrounding system.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc -- set-associative, read-only instruction cache with
// age-counter LRU replacement and a blocking, word-by-word line fill.
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : icache_assoc_if.slave (fetch request/response, memory read
//          port, flush, hit/miss statistics)
// A hit is answered combinationally in IDLE. A miss latches the address,
// picks a victim (lowest invalid way, else LRU) and fetches WORDS words in
// FILL; the retried fetch then hits. Counters saturate at all-ones.
module icache_assoc #(
  parameter int CPUID = 0,
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_assoc_if.slave bus
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int CW = (OB > 0) ? OB : 1;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                   state_q;
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [TB-1:0]            tag_q  [SETS][WAYS];
  logic [31:0]              data_q [SETS][WAYS][WORDS];
  logic [AW-1:0]            age_q  [SETS][WAYS];
  logic [TB-1:0]            mtag_q;
  logic [IB-1:0]            midx_q;
  logic [AW-1:0]            victim_q;
  logic [CW-1:0]            cnt_q;
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;

  logic [TB-1:0]   tag_s;
  logic [IB-1:0]   idx_s;
  logic [CW-1:0]   off_s;
  logic [31:0]     fill_addr_s;
  logic [WAYS-1:0] match_s;
  logic            hit_any_s;
  logic [AW-1:0]   hit_way_s;
  logic [AW-1:0]   victim_s;
  logic            ihit_s;
  logic            miss_start_s;
  logic            fill_s;
  logic            last_s;
  logic            touch_en_s;
  logic [IB-1:0]   touch_set_s;
  logic [AW-1:0]   touch_way_s;
  logic [33:0]     unused_s;

  assign tag_s    = bus.imemaddr[31 -: TB];
  assign idx_s    = bus.imemaddr[2+OB +: IB];
  assign unused_s = {bus.imemaddr[1:0], CPUID[31:0]};

  // Word offset and fill address only carry a counter field when a block has several words.
  if (OB > 0) begin : g_off
    assign off_s       = bus.imemaddr[2 +: OB];
    assign fill_addr_s = {mtag_q, midx_q, cnt_q, 2'b00};
  end else begin : g_nooff
    assign off_s       = 1'b0;
    assign fill_addr_s = {mtag_q, midx_q, 2'b00};
  end

  // Tag compare, hit-way encode and victim choice for the addressed set.
  always_comb begin
    match_s   = '0;
    hit_way_s = '0;
    victim_s  = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
      // Tags within a set are unique, so OR-encoding the match is exact.
      hit_way_s  = hit_way_s | (match_s[w] ? AW'(w) : {AW{1'b0}});
      victim_s   = victim_s | ((age_q[idx_s][w] == AW'(WAYS-1)) ? AW'(w) : {AW{1'b0}});
    end
    // Any invalid way overrides the LRU choice; scanning downward leaves the lowest.
    for (int w = WAYS-1; w >= 0; w--) begin
      victim_s = valid_q[idx_s][w] ? victim_s : AW'(w);
    end
  end

  assign hit_any_s    = |match_s;
  assign ihit_s       = nRST && (state_q == IDLE) && bus.imemREN && !bus.iflush && hit_any_s;
  assign miss_start_s = nRST && (state_q == IDLE) && bus.imemREN && !bus.iflush && !hit_any_s;
  assign fill_s       = nRST && (state_q == FILL) && !bus.iflush && !bus.iwait;
  assign last_s       = fill_s && (cnt_q == CW'(WORDS-1));

  assign touch_en_s  = ihit_s || last_s;
  assign touch_set_s = ihit_s ? idx_s : midx_q;
  assign touch_way_s = ihit_s ? hit_way_s : victim_q;

  assign hit_cnt_d  = (ihit_s && (hit_cnt_q != 32'hFFFF_FFFF)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
  assign miss_cnt_d = (miss_start_s && (miss_cnt_q != 32'hFFFF_FFFF)) ? miss_cnt_q + 32'd1 : miss_cnt_q;

  assign bus.ihit       = ihit_s;
  assign bus.imemload   = ihit_s ? data_q[idx_s][hit_way_s][off_s] : 32'd0;
  assign bus.iREN       = nRST && (state_q == FILL);
  assign bus.iaddr      = (nRST && (state_q == FILL)) ? fill_addr_s : 32'd0;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

  // Control FSM: state, valid bits, miss latch, word counter and statistics.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        IDLE: begin
          if (bus.iflush) begin
            valid_q <= '0;
          end else if (miss_start_s) begin
            mtag_q                    <= tag_s;
            midx_q                    <= idx_s;
            victim_q                  <= victim_s;
            cnt_q                     <= '0;
            // The victim is unusable while partially overwritten.
            valid_q[idx_s][victim_s]  <= 1'b0;
            state_q                   <= FILL;
          end else begin
            state_q <= IDLE;
          end
        end
        FILL: begin
          if (bus.iflush) begin
            valid_q <= '0;
            state_q <= IDLE;
          end else if (last_s) begin
            cnt_q                    <= cnt_q + CW'(1);
            valid_q[midx_q][victim_q] <= 1'b1;
            state_q                  <= IDLE;
          end else if (fill_s) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q <= FILL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // LRU ages: 0 is most recent; touching a way ages every younger way by one.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AW'(w);
        end
      end
    end else if (touch_en_s && (WAYS > 1)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way_s) begin
          age_q[touch_set_s][w] <= '0;
        end else if (age_q[touch_set_s][w] < age_q[touch_set_s][touch_way_s]) begin
          age_q[touch_set_s][w] <= age_q[touch_set_s][w] + AW'(1);
        end else begin
          age_q[touch_set_s][w] <= age_q[touch_set_s][w];
        end
      end
    end else begin
      age_q <= age_q;
    end
  end

  // Data and tag storage: written only by the fill, never reset.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      data_q[midx_q][victim_q][cnt_q] <= bus.iload;
    end
    if (last_s) begin
      tag_q[midx_q][victim_q] <= mtag_q;
    end
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter CPUID, default 0: index of this core's slot in the cache-control arrays.
REQ-002 SHALL have parameter SETS, default 8: number of sets, a power of two, 2..64.
REQ-003 SHALL have parameter WAYS, default 2: associativity, one of 1, 2, 4.
REQ-004 SHALL have parameter WORDS, default 2: 32-bit words per block, one of 1, 2, 4.
REQ-005 SHALL use reset nRST, synchronous, active-low; clock CLK.
REQ-006 CLK  in  1  clock.
REQ-007 nRST  in  1  synchronous active-low reset.
REQ-008 imemREN  in  1  datapath fetch request.
REQ-009 imemaddr  in  32  fetch byte address; bits[1:0] ignored.
REQ-010 iflush  in  1  invalidate all lines.
REQ-011 ihit  out  1  fetch satisfied this cycle.
REQ-012 imemload  out  32  fetched instruction word.
REQ-013 iREN  out  1  memory read request.
REQ-014 iaddr  out  32  memory read word address.
REQ-015 iwait  in  1  memory busy; the word is valid when low and iREN is high.
REQ-016 iload  in  32  memory read data.
REQ-017 hit_count, miss_count  out  32 each  saturating event counters.

Function
REQ-018 Address split, LSB first: 2 byte bits, log2(WORDS) word-offset bits, log2(SETS) index bits; the remaining upper bits form the tag.
REQ-019 Storage per set and way: valid bit, tag, and WORDS data words; per set: LRU state (age counter per way, width max(1, log2(WAYS))).
REQ-020 FSM states: IDLE, FILL.
REQ-021 In IDLE, ihit is combinational: imemREN AND iflush low AND some way has valid set and tag matching.
  - imemload = selected word of that way; otherwise imemload = 0.
REQ-022 A hit SHALL make the hit way the MRU of its set at the next edge and increment hit_count.
REQ-023 In IDLE, imemREN with no hit SHALL, at the next edge:
  - latch the miss address and select the victim: lowest-numbered invalid way, else the LRU way;
  - clear the word counter, increment miss_count, enter FILL.
REQ-024 In FILL, iREN=1 and iaddr = {latched tag, latched index, counter, 2'b00}; ihit=0.
REQ-025 Each FILL cycle with iwait low SHALL write iload into victim word[counter] and increment the counter.
REQ-026 On the last word (counter = WORDS-1, iwait low) the cache SHALL:
  - set the victim's valid bit and tag and make the victim MRU;
  - return to IDLE, so the retried fetch hits on the following cycle.
REQ-027 In IDLE, iREN=0 and iaddr=0.
REQ-028 imemREN deasserted or imemaddr changed during FILL SHALL NOT abort the fill; it completes for the latched address.
REQ-029 iflush high in IDLE SHALL clear all valid bits at the next edge and suppress ihit in that cycle.
REQ-030 iflush high in FILL SHALL also abort the fill:
  - the victim stays invalid, FSM returns to IDLE, iREN drops next cycle;
  - miss_count is not decremented.
REQ-031 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-032 WAYS=1 SHALL degenerate to direct-mapped with no LRU state.

Reset
REQ-033 On nRST low at an edge: FSM=IDLE, all valid bits=0, LRU ages=way index, word counter=0, hit_count=miss_count=0.
REQ-034 During and after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-035 Data and tag arrays need no reset.
REQ-036 Reset mid-FILL SHALL abandon the fill in the same edge.

Verification (SETS=8, WAYS=2, WORDS=2)
REQ-037 Cold miss: fetch 0x40, iwait low -> iaddr 0x40 then 0x44; next cycle ihit=1 with word0; miss_count=1.
REQ-038 Spatial hit: after REQ-037, fetch 0x44 -> ihit=1 same cycle, imemload=word1, hit_count=1.
REQ-039 LRU replacement: fill 0x40, 0x200, hit 0x40, then miss 0x400 -> 0x200 evicted; 0x40 still hits, 0x200 misses.
REQ-040 Wait states: iwait high 3 cycles per word -> iaddr held, 8-cycle fill, no ihit until complete.
REQ-041 Flush during fill: iflush at second FILL cycle -> IDLE next cycle, iREN=0, refetch of 0x40 misses again.
REQ-042 Reset mid-fill: nRST low in FILL -> IDLE, counters 0, fetch 0x40 misses.
